// File: rtl/turn_signal_controller_if.sv
// rtl/turn_signal_controller_if.sv - stalk/hazard inputs and lamp-sequencer request bundle
//   master: driver-side switches out, lamp requests in
//   slave : controller side (switches in, TL/TR/E/step_en/state_o out)
interface turn_signal_controller_if;
    logic       stalk_l;
    logic       stalk_r;
    logic       hazard_sw;
    logic       TL;
    logic       TR;
    logic       E;
    logic       step_en;
    logic [2:0] state_o;

    modport master (
        output stalk_l, stalk_r, hazard_sw,
        input  TL, TR, E, step_en, state_o
    );

    modport slave (
        input  stalk_l, stalk_r, hazard_sw,
        output TL, TR, E, step_en, state_o
    );
endinterface

// File: rtl/turn_signal_controller.sv
// rtl/turn_signal_controller.sv - debounce, arbitration and step timing for the sequential tail lamps
//   clk            : system clock, all state on rising edge
//   rst            : synchronous active-high reset
//   bus.stalk_l    : raw left stalk (momentary)
//   bus.stalk_r    : raw right stalk (momentary)
//   bus.hazard_sw  : raw hazard switch level
//   bus.TL/TR/E    : left / right / hazard request to the lamp sequencer (one-hot or all 0)
//   bus.step_en    : one-cycle step pulse every TICK_DIV clocks, restarted on state change
//   bus.state_o    : IDLE=0 LEFT=1 RIGHT=2 HAZARD=3 GAP=4
module turn_signal_controller #(
    parameter int DB_CYCLES = 3,
    parameter int TICK_DIV  = 4,
    parameter int MAX_STEPS = 6,
    parameter int GAP_TICKS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    turn_signal_controller_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEFT   = 3'd1,
        S_RIGHT  = 3'd2,
        S_HAZARD = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    localparam int DB_W     = $clog2(DB_CYCLES + 1);
    localparam int PS_W     = $clog2(TICK_DIV);
    localparam int STEP_LIM = (MAX_STEPS > GAP_TICKS) ? MAX_STEPS : GAP_TICKS;
    localparam int ST_W     = $clog2(STEP_LIM + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICK_DIV - 1);
    localparam logic [ST_W-1:0] MAX_LAST  = ST_W'(MAX_STEPS - 1);
    localparam logic [ST_W-1:0] GAP_LAST  = ST_W'(GAP_TICKS - 1);

    // Debounce: index 0 = left stalk, 1 = right stalk, 2 = hazard
    logic [2:0]      raw;
    logic [2:0]      db;
    logic [DB_W-1:0] db_cnt [3];
    logic [1:0]      stalk_q;

    assign raw = {bus.hazard_sw, bus.stalk_r, bus.stalk_l};

    always_ff @(posedge clk) begin
        if (rst) begin
            db      <= '0;
            stalk_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            stalk_q <= db[1:0];
            for (int i = 0; i < 3; i++) begin
                if (raw[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= raw[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Simultaneous left+right presses are treated as no press at all
    logic edge_l, edge_r, press_l, press_r, haz;
    assign edge_l  = db[0] & ~stalk_q[0];
    assign edge_r  = db[1] & ~stalk_q[1];
    assign press_l = edge_l & ~edge_r;
    assign press_r = edge_r & ~edge_l;
    assign haz     = db[2];

    state_t          state, state_next;
    state_t          target, target_next;
    logic [PS_W-1:0] presc;
    logic [ST_W-1:0] step_cnt;
    logic            step_en;
    logic            state_change;

    assign step_en      = (presc == PS_LAST);
    assign state_change = (state_next != state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            target <= S_IDLE;
        end else begin
            state  <= state_next;
            target <= target_next;
        end
    end

    always_comb begin
        state_next  = state;
        target_next = target;
        case (state)
            S_IDLE: begin
                if (haz)          state_next = S_HAZARD;
                else if (press_l) state_next = S_LEFT;
                else if (press_r) state_next = S_RIGHT;
            end
            S_LEFT: begin
                if (haz) begin
                    state_next  = S_GAP;
                    target_next = S_HAZARD;
                end else if (press_l) begin
                    state_next = S_IDLE;
                end else if (press_r) begin
                    state_next  = S_GAP;
                    target_next = S_RIGHT;
                end else if (step_en && step_cnt == MAX_LAST) begin
                    state_next = S_IDLE;
                end
            end
            S_RIGHT: begin
                if (haz) begin
                    state_next  = S_GAP;
                    target_next = S_HAZARD;
                end else if (press_r) begin
                    state_next = S_IDLE;
                end else if (press_l) begin
                    state_next  = S_GAP;
                    target_next = S_LEFT;
                end else if (step_en && step_cnt == MAX_LAST) begin
                    state_next = S_IDLE;
                end
            end
            S_HAZARD: begin
                if (!haz) state_next = S_IDLE;
            end
            S_GAP: begin
                // Target follows the latest request; exit uses this cycle's update
                if (haz)                     target_next = S_HAZARD;
                else if (press_l)            target_next = S_LEFT;
                else if (press_r)            target_next = S_RIGHT;
                else if (target == S_HAZARD) target_next = S_IDLE;
                if (step_en && step_cnt == GAP_LAST) state_next = target_next;
            end
            default: begin
                state_next  = S_IDLE;
                target_next = S_IDLE;
            end
        endcase
    end

    // Prescaler restarts on every state change so each state starts a full step
    always_ff @(posedge clk) begin
        if (rst || state_change) begin
            presc <= '0;
        end else if (step_en) begin
            presc <= '0;
        end else begin
            presc <= presc + PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state_change) begin
            step_cnt <= '0;
        end else if (step_en && (state == S_LEFT || state == S_RIGHT || state == S_GAP)) begin
            step_cnt <= step_cnt + ST_W'(1);
        end
    end

    assign bus.TL      = (state == S_LEFT);
    assign bus.TR      = (state == S_RIGHT);
    assign bus.E       = (state == S_HAZARD);
    assign bus.step_en = step_en;
    assign bus.state_o = state;

endmodule

// File: tb/tb_turn_signal_controller.sv
// tb/tb_turn_signal_controller.sv - directed and randomized checks of turn_signal_controller
module tb_turn_signal_controller;
    localparam int DB = 3;
    localparam int TD = 4;
    localparam int MS = 6;
    localparam int GT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    turn_signal_controller_if bus();

    turn_signal_controller #(
        .DB_CYCLES(DB), .TICK_DIV(TD), .MAX_STEPS(MS), .GAP_TICKS(GT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_pass   = 0;
    int n_checks = 0;

    // Reference model: timing tracked as cycles since entering the current state,
    // debounce as the run length of raw samples disagreeing with the filtered value.
    int m_state  = 0;
    int m_target = 0;
    int m_cyc    = 0;
    int m_run [3];
    bit m_db  [3];
    bit m_prev[2];

    task automatic model_edge(input bit l, input bit r, input bit h, input bit rs);
        bit raw [3];
        bit pl, pr, hz, step;
        int nxt, done;
        raw = '{l, r, h};
        if (rs) begin
            m_state = 0; m_target = 0; m_cyc = 0;
            for (int i = 0; i < 3; i++) begin m_run[i] = 0; m_db[i] = 0; end
            m_prev[0] = 0; m_prev[1] = 0;
            return;
        end
        pl = m_db[0] && !m_prev[0];
        pr = m_db[1] && !m_prev[1];
        if (pl && pr) begin pl = 0; pr = 0; end
        hz   = m_db[2];
        step = (m_cyc % TD) == TD - 1;
        done = (m_cyc + 1) / TD;
        nxt  = m_state;
        case (m_state)
            0: if (hz) nxt = 3; else if (pl) nxt = 1; else if (pr) nxt = 2;
            1: if (hz) begin nxt = 4; m_target = 3; end
               else if (pl) nxt = 0;
               else if (pr) begin nxt = 4; m_target = 2; end
               else if (step && done == MS) nxt = 0;
            2: if (hz) begin nxt = 4; m_target = 3; end
               else if (pr) nxt = 0;
               else if (pl) begin nxt = 4; m_target = 1; end
               else if (step && done == MS) nxt = 0;
            3: if (!hz) nxt = 0;
            default: begin
                if (hz) m_target = 3;
                else if (pl) m_target = 1;
                else if (pr) m_target = 2;
                else if (m_target == 3) m_target = 0;
                if (step && done == GT) nxt = m_target;
            end
        endcase
        m_cyc   = (nxt != m_state) ? 0 : m_cyc + 1;
        m_state = nxt;
        m_prev[0] = m_db[0];
        m_prev[1] = m_db[1];
        for (int i = 0; i < 3; i++) begin
            if (raw[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin m_db[i] = raw[i]; m_run[i] = 0; end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    task automatic tick(input bit l, input bit r, input bit h, input bit rs);
        @(negedge clk);
        bus.stalk_l   = l;
        bus.stalk_r   = r;
        bus.hazard_sw = h;
        rst           = rs;
        @(posedge clk);
        model_edge(l, r, h, rs);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    // Three raw samples high then one low; the state reacts on the low tick
    task automatic press(input bit left, input bit h);
        for (int i = 0; i < DB; i++) tick(left, !left, h, 0);
        tick(0, 0, h, 0);
    endtask

    task automatic test_reset;
        tick(0, 0, 0, 1);
        idle(3);
        press(1, 0);
        n_checks++;
        if (bus.state_o !== 3'd1) $display("FAIL reset_pre_left state_o=%0d exp=1", bus.state_o);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 1);
            n_checks++;
            if ({bus.state_o, bus.TL, bus.TR, bus.E, bus.step_en} !== 7'd0)
                $display("FAIL reset_hold state_o=%0d TL=%b TR=%b E=%b step_en=%b exp=all0",
                         bus.state_o, bus.TL, bus.TR, bus.E, bus.step_en);
            else n_pass++;
        end
        for (int i = 1; i <= 3; i++) begin
            tick(0, 0, 0, 0);
            n_checks++;
            if (bus.step_en !== (i == 3)) $display("FAIL reset_first_step cycle=%0d step_en=%b exp=%b", i, bus.step_en, i == 3);
            else n_pass++;
        end
    endtask

    task automatic test_glitch;
        bit bad;
        idle(4);
        bad = 0;
        tick(1, 0, 0, 0); tick(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0);
            if (bus.state_o !== 3'd0) bad = 1;
        end
        n_checks++;
        if (bad) $display("FAIL glitch_reject state_o=%0d exp=0", bus.state_o);
        else n_pass++;
        for (int i = 0; i < DB; i++) begin
            tick(1, 0, 0, 0);
            n_checks++;
            if (bus.state_o !== 3'd0) $display("FAIL glitch_early edge=%0d state_o=%0d exp=0", i + 1, bus.state_o);
            else n_pass++;
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (bus.state_o !== 3'd1 || bus.TL !== 1'b1) $display("FAIL glitch_accept state_o=%0d TL=%b exp=1/1", bus.state_o, bus.TL);
        else n_pass++;
    endtask

    task automatic test_auto_cancel;
        int n, steps;
        n = 0; steps = 0;
        while (bus.TL === 1'b1 && n < 40) begin
            tick(0, 0, 0, 0);
            n++;
            if (bus.step_en === 1'b1 && bus.TL === 1'b1) steps++;
        end
        n_checks++;
        if (n != MS * TD || bus.state_o !== 3'd0) $display("FAIL auto_cancel cycles=%0d state_o=%0d exp=%0d/0", n, bus.state_o, MS * TD);
        else n_pass++;
        n_checks++;
        if (steps != MS) $display("FAIL auto_cancel_steps got=%0d exp=%0d", steps, MS);
        else n_pass++;
        for (int i = 0; i < DB; i++) tick(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0);
            n_checks++;
            if (bus.state_o !== 3'd0) $display("FAIL both_stalks state_o=%0d exp=0", bus.state_o);
            else n_pass++;
        end
    endtask

    task automatic test_direction_change;
        int n;
        bit lamp;
        press(1, 0);
        press(0, 0);
        n_checks++;
        if (bus.state_o !== 3'd4) $display("FAIL dir_gap_enter state_o=%0d exp=4", bus.state_o);
        else n_pass++;
        n = 0; lamp = 0;
        while (bus.state_o === 3'd4 && n < 20) begin
            if (bus.TL || bus.TR || bus.E) lamp = 1;
            tick(0, 0, 0, 0);
            n++;
        end
        n_checks++;
        if (n != GT * TD || lamp) $display("FAIL dir_gap_len cycles=%0d lamp=%b exp=%0d/0", n, lamp, GT * TD);
        else n_pass++;
        n_checks++;
        if (bus.state_o !== 3'd2 || bus.TR !== 1'b1) $display("FAIL dir_right state_o=%0d TR=%b exp=2/1", bus.state_o, bus.TR);
        else n_pass++;
        idle(3);
        press(0, 0);
        n_checks++;
        if (bus.state_o !== 3'd0) $display("FAIL right_cancel state_o=%0d exp=0", bus.state_o);
        else n_pass++;
        press(1, 0);
        press(0, 0);
        press(1, 0);
        n = DB + 1;
        while (bus.state_o === 3'd4 && n < 20) begin
            tick(0, 0, 0, 0);
            n++;
        end
        n_checks++;
        if (bus.state_o !== 3'd1 || n != GT * TD) $display("FAIL gap_retarget state_o=%0d cycles=%0d exp=1/%0d", bus.state_o, n, GT * TD);
        else n_pass++;
    endtask

    task automatic test_hazard;
        int n;
        idle(3);
        press(1, 0);
        press(0, 0);
        n_checks++;
        if (bus.state_o !== 3'd2) $display("FAIL haz_pre_right state_o=%0d exp=2", bus.state_o);
        else n_pass++;
        for (int i = 0; i < DB; i++) tick(0, 0, 1, 0);
        n_checks++;
        if (bus.state_o !== 3'd2) $display("FAIL haz_latency state_o=%0d exp=2", bus.state_o);
        else n_pass++;
        tick(0, 0, 1, 0);
        n = 1;
        while (bus.state_o === 3'd4 && n < 20) begin
            tick(0, 0, 1, 0);
            n++;
        end
        n_checks++;
        if (n != GT * TD + 1 || bus.E !== 1'b1 || bus.state_o !== 3'd3)
            $display("FAIL haz_enter cycles=%0d E=%b state_o=%0d exp=%0d/1/3", n - 1, bus.E, bus.state_o, GT * TD);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            press(k == 0, 1);
            for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
            n_checks++;
            if (bus.state_o !== 3'd3 || bus.TL || bus.TR) $display("FAIL haz_ignore_press state_o=%0d exp=3", bus.state_o);
            else n_pass++;
        end
        for (int i = 0; i < DB; i++) tick(0, 0, 0, 0);
        n_checks++;
        if (bus.state_o !== 3'd3) $display("FAIL haz_release_early state_o=%0d exp=3", bus.state_o);
        else n_pass++;
        tick(0, 0, 0, 0);
        n_checks++;
        if (bus.state_o !== 3'd0 || bus.E !== 1'b0) $display("FAIL haz_release state_o=%0d E=%b exp=0/0", bus.state_o, bus.E);
        else n_pass++;
    endtask

    task automatic test_reset_in_gap;
        bit tr_seen;
        idle(4);
        press(1, 0);
        press(0, 0);
        tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        n_checks++;
        if (bus.state_o !== 3'd4) $display("FAIL gap_before_reset state_o=%0d exp=4", bus.state_o);
        else n_pass++;
        tick(0, 0, 0, 1);
        tr_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick(0, 0, 0, 0);
            if (bus.TR || bus.state_o !== 3'd0) tr_seen = 1;
        end
        n_checks++;
        if (tr_seen) $display("FAIL reset_in_gap state_o=%0d TR=%b exp=0/0", bus.state_o, bus.TR);
        else n_pass++;
    endtask

    task automatic test_random;
        bit l, r, h, rs;
        logic [6:0] exp_v;
        l = 0; r = 0; h = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0)  l = ~l;
            if ($urandom_range(0, 3) == 0)  r = ~r;
            if ($urandom_range(0, 29) == 0) h = ~h;
            rs = ($urandom_range(0, 499) == 0);
            tick(l, r, h, rs);
            exp_v = {3'(m_state), m_state == 1, m_state == 2, m_state == 3, (m_cyc % TD) == TD - 1};
            n_checks++;
            if ({bus.state_o, bus.TL, bus.TR, bus.E, bus.step_en} !== exp_v)
                $display("FAIL random cycle=%0d got={state_o,TL,TR,E,step_en}=%b exp=%b",
                         c, {bus.state_o, bus.TL, bus.TR, bus.E, bus.step_en}, exp_v);
            else n_pass++;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.stalk_l   = 1'b0;
        bus.stalk_r   = 1'b0;
        bus.hazard_sw = 1'b0;
        test_reset();
        test_glitch();
        test_auto_cancel();
        test_direction_change();
        test_hazard();
        test_reset_in_gap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
